// File: rtl/sparse_pkg.sv
// Shared definitions for the sparse encoding path: element geometry defaults
// and the encoder state encoding.
package sparse_pkg;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned VEC_LEN_DEF = 64;
  localparam int unsigned ADDR_W_DEF  = 6;
  localparam int unsigned NZ_W        = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } enc_state_e;

endpackage

// File: rtl/sparse_encoder.sv
// Dense-to-sparse encoder: scans one vector and writes each nonzero element,
// with its dense position, into the nonzero buffer one cycle after acceptance.
module sparse_encoder
  import sparse_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned VEC_LEN = VEC_LEN_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] wr_index,
  output logic [NZ_W-1:0]   nz_count,
  output logic              done
);

  enc_state_e        state;
  logic [ADDR_W-1:0] pos;

  // Single-process FSM; every output is a register so done lines up with the final write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pos      <= '0;
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_index <= '0;
      nz_count <= '0;
      done     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SCAN;
            in_ready <= 1'b1;
            nz_count <= '0;
            pos      <= '0;
          end
        end
        SCAN: begin
          if (in_valid && in_ready) begin
            pos <= pos + ADDR_W'(1);
            if (in_data != '0) begin
              wr_en    <= 1'b1;
              wr_addr  <= nz_count[ADDR_W-1:0];
              wr_data  <= in_data;
              wr_index <= pos;
              nz_count <= nz_count + NZ_W'(1);
            end
            // The VEC_LEN-th element closes the vector even without in_last.
            if (in_last || (pos == ADDR_W'(VEC_LEN - 1))) begin
              state    <= DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_encoder.sv
// Directed, table-driven bench for sparse_encoder with hand-computed expectations.
module tb_sparse_encoder;

  logic       clk;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic [5:0] wr_index;
  logic [7:0] nz_count;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;
  int done_seen = 0;

  sparse_encoder #(.DATA_W(8), .VEC_LEN(64), .ADDR_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_index (wr_index),
    .nz_count (nz_count),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  typedef struct {
    logic       start;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       e_ready;
    logic       e_wr;
    logic [5:0] e_addr;
    logic [7:0] e_data;
    logic [5:0] e_idx;
    logic [7:0] e_nz;
    logic       e_done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic s, input logic v, input logic [7:0] d, input logic l,
                              input logic r, input logic w, input logic [5:0] a,
                              input logic [7:0] wd, input logic [5:0] ix, input logic [7:0] nz,
                              input logic dn);
    vec_t t;
    t.start = s; t.valid = v; t.data = d; t.last = l;
    t.e_ready = r; t.e_wr = w; t.e_addr = a; t.e_data = wd; t.e_idx = ix;
    t.e_nz = nz; t.e_done = dn;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic v, input logic [7:0] d, input logic l);
    start = s; in_valid = v; in_data = d; in_last = l;
  endtask

  // Apply one cycle of inputs, then sample the registered outputs 1 time unit after the edge.
  task automatic step(input logic s, input logic v, input logic [7:0] d, input logic l);
    drive(s, v, d, l);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 0);
    chk({tag, ".wr_en"},    32'(wr_en),    0);
    chk({tag, ".wr_addr"},  32'(wr_addr),  0);
    chk({tag, ".wr_data"},  32'(wr_data),  0);
    chk({tag, ".wr_index"}, 32'(wr_index), 0);
    chk({tag, ".nz_count"}, 32'(nz_count), 0);
    chk({tag, ".done"},     32'(done),     0);
  endtask

  initial begin
    int done_before;
    vec_t t;

    drive(1'b0, 1'b0, 8'd0, 1'b0);
    reset = 1'b1;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Stream 0,5,0,7 with last on 7.
    tbl.push_back(mk(1, 0, 8'd0, 0,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'd0, 0,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'd5, 0,  1, 1, 0, 5, 1, 1, 0));
    tbl.push_back(mk(0, 1, 8'd0, 0,  1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'd7, 1,  0, 1, 1, 7, 3, 2, 1));
    tbl.push_back(mk(0, 0, 8'd0, 0,  0, 0, 0, 0, 0, 2, 0));
    // Valid toggling 1,0,1 on 3,x,4; start pulsed mid-scan is ignored.
    tbl.push_back(mk(1, 0, 8'd0, 0,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'd3, 0,  1, 1, 0, 3, 0, 1, 0));
    tbl.push_back(mk(1, 0, 8'd9, 0,  1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'd4, 1,  0, 1, 1, 4, 1, 2, 1));
    tbl.push_back(mk(0, 0, 8'd0, 0,  0, 0, 0, 0, 0, 2, 0));
    // in_valid outside SCAN has no effect; nz_count holds.
    tbl.push_back(mk(0, 1, 8'd8, 0,  0, 0, 0, 0, 0, 2, 0));
    // Ten zeros, last on the tenth.
    tbl.push_back(mk(1, 0, 8'd0, 0,  1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(0, 1, 8'd0, (i == 9), (i != 9), 0, 0, 0, 0, 0, (i == 9)));
    tbl.push_back(mk(0, 0, 8'd0, 0,  0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      step(t.start, t.valid, t.data, t.last);
      chk($sformatf("tbl[%0d].in_ready", i), 32'(in_ready), 32'(t.e_ready));
      chk($sformatf("tbl[%0d].wr_en", i),    32'(wr_en),    32'(t.e_wr));
      chk($sformatf("tbl[%0d].nz_count", i), 32'(nz_count), 32'(t.e_nz));
      chk($sformatf("tbl[%0d].done", i),     32'(done),     32'(t.e_done));
      if (t.e_wr) begin
        chk($sformatf("tbl[%0d].wr_addr", i),  32'(wr_addr),  32'(t.e_addr));
        chk($sformatf("tbl[%0d].wr_data", i),  32'(wr_data),  32'(t.e_data));
        chk($sformatf("tbl[%0d].wr_index", i), 32'(wr_index), 32'(t.e_idx));
      end
    end

    // Full 64-element vector without in_last: length alone terminates it.
    step(1'b1, 1'b0, 8'd0, 1'b0);
    chk("full.ready_at_start", 32'(in_ready), 1);
    for (int i = 0; i < 64; i++) begin
      step(1'b0, 1'b1, 8'(i + 1), 1'b0);
      chk($sformatf("full[%0d].wr_en", i),    32'(wr_en),    1);
      chk($sformatf("full[%0d].wr_addr", i),  32'(wr_addr),  32'(i));
      chk($sformatf("full[%0d].wr_data", i),  32'(wr_data),  32'(i + 1));
      chk($sformatf("full[%0d].wr_index", i), 32'(wr_index), 32'(i));
      chk($sformatf("full[%0d].nz_count", i), 32'(nz_count), 32'(i + 1));
      chk($sformatf("full[%0d].done", i),     32'(done),     32'(i == 63));
    end
    step(1'b0, 1'b1, 8'd99, 1'b0);
    chk("full.post.wr_en",    32'(wr_en),    0);
    chk("full.post.done",     32'(done),     0);
    chk("full.post.nz_count", 32'(nz_count), 64);
    step(1'b0, 1'b1, 8'd99, 1'b0);
    chk("full.idle.in_ready", 32'(in_ready), 0);
    chk("full.idle.wr_en",    32'(wr_en),    0);

    // Reset in the middle of a six-element vector.
    step(1'b1, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b1, 8'd10, 1'b0);
    step(1'b0, 1'b1, 8'd20, 1'b0);
    step(1'b0, 1'b1, 8'd30, 1'b0);
    chk("rst.pre.wr_en",    32'(wr_en),    1);
    chk("rst.pre.nz_count", 32'(nz_count), 3);
    drive(1'b0, 1'b1, 8'd40, 1'b0);
    #2;
    done_before = done_seen;
    reset = 1'b1;
    #1;
    chk_all_zero("rst.async");
    drive(1'b0, 1'b0, 8'd0, 1'b0);
    @(posedge clk);
    #1;
    chk_all_zero("rst.held");
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.no_done", 32'(done_seen), 32'(done_before));
    chk("rst.idle.in_ready", 32'(in_ready), 0);
    step(1'b1, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b1, 8'd55, 1'b1);
    chk("rst.re.wr_en",    32'(wr_en),    1);
    chk("rst.re.wr_addr",  32'(wr_addr),  0);
    chk("rst.re.wr_data",  32'(wr_data),  55);
    chk("rst.re.wr_index", 32'(wr_index), 0);
    chk("rst.re.nz_count", 32'(nz_count), 1);
    chk("rst.re.done",     32'(done),     1);
    step(1'b0, 1'b0, 8'd0, 1'b0);
    chk("rst.re.done_clear", 32'(done), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
